// File: rtl/inverter_arb_pkg.sv
// rtl/inverter_arb_pkg.sv - shared types and constants for the inverter job arbiter
// Purpose: FSM state encoding, job status codes, timing constants and the
//          beat-limit helper used by inverter_job_arbiter and rr_arbiter2.
// Ports:   none (package).
package inverter_arb_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RST     = 3'd1,
    S_LOAD0   = 3'd2,
    S_LOAD    = 3'd3,
    S_COMPUTE = 3'd4,
    S_DRAIN   = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    STATUS_OK        = 2'd0,
    STATUS_SINGULAR  = 2'd1,
    STATUS_BAD_ORDER = 2'd2,
    STATUS_TIMEOUT   = 2'd3
  } status_t;

  localparam logic [7:0]  RST_CYCLES   = 8'd2;
  localparam logic [15:0] WATCHDOG_MAX = 16'hFFFF;
  localparam logic [3:0]  MAX_ORDER    = 4'd15;

  // Number of row-major beats in an order x order matrix; 15*15 fits in 8 bits.
  function automatic logic [7:0] beat_limit(input logic [3:0] order);
    return {4'd0, order} * {4'd0, order};
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-input round-robin grant with last-served pointer
// Purpose: combinational one-hot grant for two requesters; on a tie the
//          requester not served last wins. The pointer moves only when the
//          owning job finishes.
// Ports:   clk, rst_n (async active-low), req_i[1:0], update_i (job finished),
//          served_i[1:0] (one-hot owner of the finished job), gnt_o[1:0].
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       update_i,
  input  logic [1:0] served_i,
  output logic [1:0] gnt_o
);

  // 1 means requester 1 was served last, so requester 0 wins the next tie.
  logic last_q;
  logic last_d;

  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

  always_comb begin
    last_d = last_q;
    if (update_i) begin
      last_d = served_i[1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/inverter_job_arbiter.sv
// rtl/inverter_job_arbiter.sv - shares one matrix inverter between two requesters
// Purpose: arbitrates jobs, resets the inverter, streams the owner's elements
//          in, waits for the result with a watchdog, streams the result out and
//          reports a per-job status with a one-cycle done pulse.
// Ports:   clk, rst (async active-low); req[1:0], req_order0/1[3:0],
//          in_data0/1[15:0] from requesters; grant[1:0], elem_req to them;
//          inv_rst, inv_order[3:0], inv_data[15:0] to the inverter;
//          inv_ready, inv_invertible, inv_result[15:0] from it;
//          out_valid, out_last, out_data[15:0] result stream; done[1:0], status[1:0].
module inverter_job_arbiter
  import inverter_arb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [3:0]  req_order0,
  input  logic [3:0]  req_order1,
  input  logic [15:0] in_data0,
  input  logic [15:0] in_data1,
  output logic [1:0]  grant,
  output logic        elem_req,
  output logic        inv_rst,
  output logic [3:0]  inv_order,
  output logic [15:0] inv_data,
  input  logic        inv_ready,
  input  logic        inv_invertible,
  input  logic [15:0] inv_result,
  output logic        out_valid,
  output logic        out_last,
  output logic [15:0] out_data,
  output logic [1:0]  done,
  output logic [1:0]  status
);

  state_t      state_q,   state_d;
  logic [1:0]  grant_q,   grant_d;
  logic [3:0]  order_q,   order_d;
  logic [7:0]  limit_q,   limit_d;
  logic [7:0]  cnt_q,     cnt_d;
  logic [15:0] wd_q,      wd_d;
  status_t     status_q,  status_d;
  logic        inv_rst_q, inv_rst_d;

  logic [1:0]  arb_gnt;
  logic        arb_update;
  logic [3:0]  sel_order;

  rr_arbiter2 u_arb (
    .clk      (clk),
    .rst_n    (rst),
    .req_i    (req),
    .update_i (arb_update),
    .served_i (grant_q),
    .gnt_o    (arb_gnt)
  );

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    order_d    = order_q;
    limit_d    = limit_q;
    cnt_d      = cnt_q;
    wd_d       = wd_q;
    status_d   = status_q;
    inv_rst_d  = inv_rst_q;
    elem_req   = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    done       = 2'b00;
    arb_update = 1'b0;
    sel_order  = arb_gnt[1] ? req_order1 : req_order0;

    case (state_q)
      S_IDLE: begin
        inv_rst_d = 1'b0;
        if (arb_gnt != 2'b00) begin
          grant_d  = arb_gnt;
          order_d  = sel_order;
          limit_d  = beat_limit(sel_order);
          cnt_d    = 8'd0;
          status_d = STATUS_OK;
          state_d  = S_RST;
        end
      end
      S_RST: begin
        // A zero-order job still sits through the reset window but never
        // releases the inverter.
        if (cnt_q == RST_CYCLES - 8'd1) begin
          cnt_d = 8'd0;
          if (order_q == 4'd0) begin
            status_d = STATUS_BAD_ORDER;
            state_d  = S_DONE;
          end else begin
            inv_rst_d = 1'b1;
            state_d   = S_LOAD0;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_LOAD0: begin
        cnt_d   = 8'd0;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        elem_req = 1'b1;
        if (cnt_q == limit_q - 8'd1) begin
          cnt_d   = 8'd0;
          wd_d    = 16'd0;
          state_d = S_COMPUTE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_COMPUTE: begin
        if (inv_ready) begin
          if (inv_invertible) begin
            cnt_d   = 8'd0;
            state_d = S_DRAIN;
          end else begin
            status_d = STATUS_SINGULAR;
            state_d  = S_DONE;
          end
        end else if (wd_q == WATCHDOG_MAX - 16'd1) begin
          status_d = STATUS_TIMEOUT;
          state_d  = S_DONE;
        end else begin
          wd_d = wd_q + 16'd1;
        end
      end
      S_DRAIN: begin
        out_valid = 1'b1;
        out_last  = (cnt_q == limit_q - 8'd1);
        if (out_last) begin
          cnt_d   = 8'd0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE: begin
        done       = grant_q;
        arb_update = 1'b1;
        grant_d    = 2'b00;
        order_d    = 4'd0;
        cnt_d      = 8'd0;
        wd_d       = 16'd0;
        inv_rst_d  = 1'b0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      grant_q   <= 2'b00;
      order_q   <= 4'd0;
      limit_q   <= 8'd0;
      cnt_q     <= 8'd0;
      wd_q      <= 16'd0;
      status_q  <= STATUS_OK;
      inv_rst_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      order_q   <= order_d;
      limit_q   <= limit_d;
      cnt_q     <= cnt_d;
      wd_q      <= wd_d;
      status_q  <= status_d;
      inv_rst_q <= inv_rst_d;
    end
  end

  assign grant     = grant_q;
  assign inv_rst   = inv_rst_q;
  assign inv_order = order_q;
  assign status    = status_q;
  assign out_data  = inv_result;
  assign inv_data  = grant_q[1] ? in_data1 : (grant_q[0] ? in_data0 : 16'd0);

endmodule
